// File: rtl/data_io_pkg.sv
// Shared definitions for the data_io load/store alignment block: RISC-V funct3
// access encodings, field positions and small decode helpers.
package data_io_pkg;

  localparam int DATA_W = 32;
  localparam int TYPE_W = 3;
  localparam int OFFS_W = 2;

  // Field positions inside data_type (funct3)
  localparam int SIZE_LSB = 0;
  localparam int SIZE_MSB = 1;
  localparam int EXT_BIT  = 2;

  // funct3 access encodings
  localparam logic [TYPE_W-1:0] DT_LB  = 3'b000;
  localparam logic [TYPE_W-1:0] DT_LH  = 3'b001;
  localparam logic [TYPE_W-1:0] DT_LW  = 3'b010;
  localparam logic [TYPE_W-1:0] DT_LBU = 3'b100;
  localparam logic [TYPE_W-1:0] DT_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    size_e size;
    logic  zero_ext;
  } access_t;

  // Both 1x size codes map to a full word.
  function automatic size_e decode_size(input logic [TYPE_W-1:0] dt);
    logic [1:0] sz;
    sz = dt[SIZE_MSB:SIZE_LSB];
    case (sz)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic access_t decode_access(input logic [TYPE_W-1:0] dt);
    access_t a;
    a.size     = decode_size(dt);
    a.zero_ext = dt[EXT_BIT];
    return a;
  endfunction

  // Byte offset to bit shift amount.
  function automatic logic [4:0] lane_shift(input logic [OFFS_W-1:0] offs);
    return {offs, 3'b000};
  endfunction

endpackage

// File: rtl/data_io_load_align.sv
// Combinational load extraction: selects the addressed byte/half of the raw
// word and sign- or zero-extends it to 32 bits.
module load_align
  import data_io_pkg::*;
(
  input  logic [DATA_W-1:0] load_word,
  input  logic [TYPE_W-1:0] data_type,
  input  logic [OFFS_W-1:0] data_offset,
  output logic [DATA_W-1:0] cpu_out
);

  access_t           acc;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  always_comb begin
    acc     = decode_access(data_type);
    shifted = load_word >> lane_shift(data_offset);
  end

  // A half at offset 3 sees zeros shifted into bits 15:8, so its sign is 0.
  always_comb begin
    sign_bit = 1'b0;
    case (acc.size)
      SZ_BYTE: sign_bit = shifted[7]  & ~acc.zero_ext;
      SZ_HALF: sign_bit = shifted[15] & ~acc.zero_ext;
      default: sign_bit = 1'b0;
    endcase
  end

  always_comb begin
    cpu_out = load_word;
    case (acc.size)
      SZ_BYTE: cpu_out = {{24{sign_bit}}, shifted[7:0]};
      SZ_HALF: cpu_out = {{16{sign_bit}}, shifted[15:0]};
      default: cpu_out = load_word;
    endcase
  end

endmodule

// File: rtl/data_io.sv
// Load/store data path between CPU and bus: captures store and load words,
// then lane-positions store data and aligns/extends load data combinationally.
module data_io
  import data_io_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              store,
  input  logic              load,
  input  logic [TYPE_W-1:0] data_type,
  input  logic [OFFS_W-1:0] data_offset,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] cpu_out,
  output logic [DATA_W-1:0] io_out
);

  logic [DATA_W-1:0] store_d, store_q;
  logic [DATA_W-1:0] load_d,  load_q;

  always_comb begin
    store_d = store_q;
    load_d  = load_q;
    if (store) store_d = cpu_in;
    if (load)  load_d  = io_in;
  end

  // Reset wins over any capture requested in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      store_q <= '0;
      load_q  <= '0;
    end else begin
      store_q <= store_d;
      load_q  <= load_d;
    end
  end

  load_align u_load_align (
    .load_word  (load_q),
    .data_type  (data_type),
    .data_offset(data_offset),
    .cpu_out    (cpu_out)
  );

  size_e      st_size;
  logic [4:0] st_shift;

  // Bits pushed past bit 31 by a high offset are simply dropped.
  always_comb begin
    st_size  = decode_size(data_type);
    st_shift = lane_shift(data_offset);
    io_out   = store_q;
    case (st_size)
      SZ_BYTE: io_out = {24'd0, store_q[7:0]}  << st_shift;
      SZ_HALF: io_out = {16'd0, store_q[15:0]} << st_shift;
      default: io_out = store_q;
    endcase
  end

endmodule

// File: tb/tb_data_io.sv
// Directed self-checking bench for data_io.
module tb_data_io;

  logic        clock = 1'b0;
  logic        reset, store, load;
  logic [2:0]  data_type;
  logic [1:0]  data_offset;
  logic [31:0] cpu_in, io_in, cpu_out, io_out;

  int errors = 0;
  int checks = 0;

  data_io dut (
    .clock      (clock),
    .reset      (reset),
    .store      (store),
    .load       (load),
    .data_type  (data_type),
    .data_offset(data_offset),
    .cpu_in     (cpu_in),
    .io_in      (io_in),
    .cpu_out    (cpu_out),
    .io_out     (io_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-14s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic sel(input logic [2:0] t, input logic [1:0] o);
    data_type   = t;
    data_offset = o;
    #1;
  endtask

  initial begin
    reset = 1'b1; store = 1'b0; load = 1'b0;
    data_type = 3'b010; data_offset = 2'd0;
    cpu_in = 32'h0; io_in = 32'h0;
    tick();
    reset = 1'b0;
    check("rst_cpu", cpu_out, 32'h0000_0000);
    check("rst_io",  io_out,  32'h0000_0000);

    // Loads of 0xDDCCBBAA
    load = 1'b1; io_in = 32'hDDCC_BBAA;
    tick();
    load = 1'b0;
    sel(3'b000, 2'd0); check("lb_o0",   cpu_out, 32'hFFFF_FFAA);
    sel(3'b001, 2'd0); check("lh_o0",   cpu_out, 32'hFFFF_BBAA);
    sel(3'b010, 2'd0); check("lw_o0",   cpu_out, 32'hDDCC_BBAA);
    sel(3'b010, 2'd3); check("lw_o3",   cpu_out, 32'hDDCC_BBAA);
    sel(3'b110, 2'd1); check("t110_o1", cpu_out, 32'hDDCC_BBAA);
    sel(3'b100, 2'd1); check("lbu_o1",  cpu_out, 32'h0000_00BB);
    sel(3'b101, 2'd2); check("lhu_o2",  cpu_out, 32'h0000_DDCC);
    sel(3'b100, 2'd3); check("lbu_o3",  cpu_out, 32'h0000_00DD);
    sel(3'b001, 2'd1); check("lh_o1",   cpu_out, 32'hFFFF_CCBB);
    sel(3'b001, 2'd3); check("lh_o3",   cpu_out, 32'h0000_00DD);
    sel(3'b000, 2'd3); check("lb_o3",   cpu_out, 32'hFFFF_FFDD);
    sel(3'b000, 2'd1); check("lb_o1",   cpu_out, 32'hFFFF_FFBB);

    // Stores of 0xDDCCBBAA
    store = 1'b1; cpu_in = 32'hDDCC_BBAA;
    tick();
    store = 1'b0;
    sel(3'b000, 2'd1); check("sb_o1",   io_out, 32'h0000_AA00);
    sel(3'b001, 2'd2); check("sh_o2",   io_out, 32'hBBAA_0000);
    sel(3'b010, 2'd1); check("sw_o1",   io_out, 32'hDDCC_BBAA);
    sel(3'b001, 2'd3); check("sh_o3",   io_out, 32'hAA00_0000);
    sel(3'b000, 2'd0); check("sb_o0",   io_out, 32'h0000_00AA);
    sel(3'b100, 2'd2); check("sbu_o2",  io_out, 32'h00AA_0000);

    // Hold with strobes low
    io_in = 32'h1234_5678; cpu_in = 32'h1111_1111;
    tick();
    sel(3'b010, 2'd0);
    check("hold_cpu", cpu_out, 32'hDDCC_BBAA);
    check("hold_io",  io_out,  32'hDDCC_BBAA);

    // Simultaneous capture
    load = 1'b1; store = 1'b1; io_in = 32'h80FF_7F01; cpu_in = 32'h0000_C3A5;
    tick();
    load = 1'b0; store = 1'b0;
    sel(3'b000, 2'd0); check("both_lb0",  cpu_out, 32'h0000_0001);
    sel(3'b000, 2'd1); check("both_lb1",  cpu_out, 32'h0000_007F);
    sel(3'b000, 2'd2); check("both_lb2",  cpu_out, 32'hFFFF_FFFF);
    sel(3'b001, 2'd2); check("both_lh2",  cpu_out, 32'hFFFF_80FF);
    sel(3'b101, 2'd2); check("both_lhu2", cpu_out, 32'h0000_80FF);
    sel(3'b001, 2'd1); check("both_sh1",  io_out,  32'h00C3_A500);
    sel(3'b000, 2'd3); check("both_sb3",  io_out,  32'hA500_0000);

    // Reset beats simultaneous capture
    reset = 1'b1; load = 1'b1; store = 1'b1;
    io_in = 32'hFFFF_FFFF; cpu_in = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0; load = 1'b0; store = 1'b0;
    sel(3'b010, 2'd0);
    check("rstp_cpu", cpu_out, 32'h0000_0000);
    check("rstp_io",  io_out,  32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_io.md
DATA_IO -- requirements
Module: data_io

Interface
- REQ-001 SHALL have port `clock`: input, 1 bit, the single clock; all state updates on the rising edge.
- REQ-002 SHALL have port `reset`: input, 1 bit, synchronous active-high reset.
- REQ-003 SHALL have port `store`: input, 1 bit; when high, cpu_in is captured at the clock edge.
- REQ-004 SHALL have port `load`: input, 1 bit; when high, io_in is captured at the clock edge.
- REQ-005 SHALL have port `data_type`: input, 3 bits, RISC-V funct3 access type (bit2 = unsigned; bits[1:0] = size).
- REQ-006 SHALL have port `data_offset`: input, 2 bits, byte address bits [1:0] of the access.
- REQ-007 SHALL have port `cpu_in`: input, 32 bits, store data from the CPU register file.
- REQ-008 SHALL have port `io_in`: input, 32 bits, raw word read from memory/bus.
- REQ-009 SHALL have port `cpu_out`: output, 32 bits, aligned and extended load result to the CPU.
- REQ-010 SHALL have port `io_out`: output, 32 bits, lane-positioned store word to memory/bus.

Function
- REQ-011 SHALL hold a 32-bit store register that loads cpu_in on a rising edge with store=1, and holds otherwise.
- REQ-012 SHALL hold a 32-bit load register that loads io_in on a rising edge with load=1, and holds otherwise.
- REQ-013 SHALL capture store and load independently; both high in the same cycle captures both registers.
- REQ-014 SHALL decode size from data_type[1:0]: 00 = byte, 01 = halfword, 1x = word (covers 010, 011, 110 and 111).
- REQ-015 SHALL decode extension from data_type[2]: 0 = sign-extend, 1 = zero-extend; the extension bit is ignored for word size.
- REQ-016 SHALL drive cpu_out combinationally from the load register and the current data_type/data_offset; changes to data_type/data_offset take effect without a new load.
- REQ-017 SHALL form cpu_out for byte/half as: s = load_reg >> (8*data_offset); take s[7:0] or s[15:0]; extend to 32 bits per REQ-015.
- REQ-018 SHALL handle misaligned halfwords without a fault: at offset 3, s[15:8]=0, so the sign bit is 0.
- REQ-019 SHALL pass the load register unchanged to cpu_out for word size, ignoring data_offset.
- REQ-020 SHALL drive io_out combinationally from the store register as: byte = store_reg[7:0] << (8*offset); half = store_reg[15:0] << (8*offset), with bits shifted past bit 31 discarded; all other lanes zero.
- REQ-021 SHALL pass the store register unchanged to io_out for word size, ignoring data_offset.
- REQ-022 SHALL add no latency beyond the single capture edge; outputs are valid in the cycle after capture.

Reset
- REQ-023 SHALL clear both registers to 0 on a rising edge with reset=1; reset has priority over store/load, so cpu_out = 0 and io_out = 0 the following cycle.
- REQ-024 SHALL discard a capture requested in the same cycle as reset (reset mid-operation).

Structure
- REQ-025 SHALL define in shared package data_io_pkg: data_type encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101) and size/extension field positions.
- REQ-026 SHALL implement load extraction/extension as one combinational sub-module, load_align; store lane shifting stays inline.

Verification
- REQ-027 SHALL verify signed loads: load 0xDDCCBBAA; type 000, offset 0 -> cpu_out FFFFFFAA; type 001, offset 0 -> FFFFBBAA; type 010 -> DDCCBBAA.
- REQ-028 SHALL verify unsigned loads at offsets: type 100, offset 1 -> 000000BB; type 101, offset 2 -> 0000DDCC; type 100, offset 3 -> 000000DD.
- REQ-029 SHALL verify misaligned half: type 001, offset 1 -> FFFFCCBB; type 001, offset 3 -> 000000DD.
- REQ-030 SHALL verify store lanes: store 0xDDCCBBAA; type 000, offset 1 -> io_out 0000AA00; type 001, offset 2 -> BBAA0000; type 010 -> DDCCBBAA.
- REQ-031 SHALL verify hold: with load=0, io_in changed to 0x12345678 -> cpu_out unchanged; with store=0, cpu_in changed -> io_out unchanged.
- REQ-032 SHALL verify reset priority: reset=1 together with load=1 and store=1 -> next cycle cpu_out = 0 and io_out = 0.
